// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   localparam int          FIFO_DEPTH = 2;
   localparam logic [31:0] PC_INCR    = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + PC_INCR;
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} prefetch buffer. Entry 0 is always the head, so the
// head output keeps its last value when the buffer drains or is flushed.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t wr_entry_i,
   output fetch_entry_t head_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [1:0]   count_o
);

   fetch_entry_t ent0_q, ent0_d;
   fetch_entry_t ent1_q, ent1_d;
   logic [1:0]   count_q, count_d;

   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (count_q == 2'd0) ent0_d = wr_entry_i;
               else                 ent1_d = wr_entry_i;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) ent0_d = ent1_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               // count unchanged; the new entry lands behind whatever remains
               if (count_q == 2'd2) begin
                  ent0_d = ent1_q;
                  ent1_d = wr_entry_i;
               end else begin
                  ent0_d = wr_entry_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

   assign head_o  = ent0_q;
   assign full_o  = (count_q == 2'(DEPTH));
   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer: drives the PC into a combinational instruction memory and
// feeds a two-entry prefetch buffer towards decode.
//
// state  | meaning
// IDLE   | just out of reset, no fetch yet
// FETCH  | fetching one word per cycle while the buffer has room
// HALTED | fetch suspended, buffer still drains to decode
module instruction_fetch_controller #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = fetch_pkg::FIFO_DEPTH
) (
   input  logic        Clk,
   input  logic        Rst,
   output logic [31:0] ImemAddress,
   input  logic [31:0] ImemInstruction,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   input  logic        Halt,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] InstrOut,
   output logic [31:0] InstrPC,
   output logic [1:0]  FetchState
);

   import fetch_pkg::*;

   fetch_state_e state_q;
   logic [31:0]  pc_q, pc_d;
   logic         push, pop;
   logic         fifo_full, fifo_empty;
   logic [1:0]   fifo_count;
   fetch_entry_t wr_entry, head;
   logic         unused_bits;

   assign unused_bits = ^{RedirectTarget[1:0], fifo_count};

   assign pop  = InstrValid & InstrReady & ~Redirect;
   assign push = (state_q == ST_FETCH) & ~Halt & ~Redirect & (~fifo_full | pop);

   assign wr_entry = '{pc: pc_q, instr: ImemInstruction};

   always_comb begin
      pc_d = pc_q;
      if (Redirect)  pc_d = word_align(RedirectTarget);
      else if (push) pc_d = pc_next(pc_q);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         pc_q <= pc_d;
         case (state_q)
            ST_IDLE:   state_q <= ST_FETCH;
            ST_FETCH:  if (Halt)  state_q <= ST_HALTED;
            ST_HALTED: if (!Halt) state_q <= ST_FETCH;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (Clk),
      .rst_n_i   (Rst),
      .push_i    (push),
      .pop_i     (pop),
      .flush_i   (Redirect),
      .wr_entry_i(wr_entry),
      .head_o    (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   assign ImemAddress = pc_q;
   assign InstrValid  = ~fifo_empty;
   assign InstrOut    = head.instr;
   assign InstrPC     = head.pc;
   assign FetchState  = state_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed and randomized bench for instruction_fetch_controller against a
// queue-based model of the fetch stream.
module tb_instruction_fetch_controller;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic [31:0] ImemAddress;
   logic [31:0] ImemInstruction;
   logic        Redirect = 1'b0;
   logic [31:0] RedirectTarget = '0;
   logic        Halt = 1'b0;
   logic        InstrValid;
   logic        InstrReady = 1'b1;
   logic [31:0] InstrOut;
   logic [31:0] InstrPC;
   logic [1:0]  FetchState;

   int total = 0;
   int bad   = 0;

   // model state
   logic [63:0] q[$];
   logic [31:0] pc_m;
   int          mode_m;
   logic [31:0] shown_pc, shown_instr;

   always #5 Clk = ~Clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   assign ImemInstruction = mem_f(ImemAddress);

   instruction_fetch_controller #(
      .RESET_PC  (32'h0000_0000),
      .FIFO_DEPTH(2)
   ) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .ImemAddress    (ImemAddress),
      .ImemInstruction(ImemInstruction),
      .Redirect       (Redirect),
      .RedirectTarget (RedirectTarget),
      .Halt           (Halt),
      .InstrValid     (InstrValid),
      .InstrReady     (InstrReady),
      .InstrOut       (InstrOut),
      .InstrPC        (InstrPC),
      .FetchState     (FetchState)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      pc_m        = 32'h0;
      mode_m      = 0;
      shown_pc    = 32'h0;
      shown_instr = 32'h0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'(InstrValid), 32'(q.size() != 0));
      chk({tag, ".instr"}, InstrOut, shown_instr);
      chk({tag, ".ipc"},   InstrPC, shown_pc);
      chk({tag, ".state"}, 32'(FetchState), 32'(mode_m));
      chk({tag, ".addr"},  ImemAddress, pc_m);
   endtask

   // One clock: model consumes the current inputs, then the DUT is compared.
   task automatic cycle(input string tag);
      bit          pop, push;
      logic [31:0] instr;
      pop = (q.size() != 0) && InstrReady;
      if (Redirect) begin
         pc_m = RedirectTarget & 32'hFFFF_FFFC;
         q.delete();
      end else begin
         push  = (mode_m == 1) && !Halt && ((q.size() < 2) || pop);
         instr = mem_f(pc_m);
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back({pc_m, instr});
            pc_m = pc_m + 32'd4;
         end
      end
      if (mode_m == 0)                mode_m = 1;
      else if (mode_m == 1 && Halt)   mode_m = 2;
      else if (mode_m == 2 && !Halt)  mode_m = 1;
      if (q.size() != 0) {shown_pc, shown_instr} = q[0];
      @(posedge Clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #1;
      check_all("reset");

      // release and stream with decode always ready
      @(posedge Clk); #1;
      Rst = 1'b1;
      cycle("rel1");
      chk("first_edge_no_valid", 32'(InstrValid), 32'd0);
      cycle("rel2");
      chk("second_edge_valid", 32'(InstrValid), 32'd1);
      chk("second_edge_pc", InstrPC, 32'h0);
      for (int i = 0; i < 6; i++) cycle("stream");

      // back-pressure: buffer fills, PC holds
      InstrReady = 1'b0;
      for (int i = 0; i < 5; i++) cycle("stall");
      InstrReady = 1'b1;
      for (int i = 0; i < 4; i++) cycle("unstall");

      // redirect while full
      InstrReady = 1'b0;
      cycle("fill"); cycle("fill");
      Redirect = 1'b1; RedirectTarget = 32'h43;
      cycle("redir");
      chk("redir_valid", 32'(InstrValid), 32'd0);
      chk("redir_addr", ImemAddress, 32'h40);
      Redirect = 1'b0; InstrReady = 1'b1;
      cycle("post_redir");
      chk("redir_first_pc", InstrPC, 32'h40);
      for (int i = 0; i < 3; i++) cycle("post_redir");

      // halt: drain, freeze, resume
      Halt = 1'b1;
      for (int i = 0; i < 4; i++) cycle("halt");
      chk("halt_state", 32'(FetchState), 32'd2);
      chk("halt_empty", 32'(InstrValid), 32'd0);
      // redirect while halted stays halted
      Redirect = 1'b1; RedirectTarget = 32'h0000_0200;
      cycle("halt_redir");
      chk("halt_redir_state", 32'(FetchState), 32'd2);
      Redirect = 1'b0;
      cycle("halt_hold");
      Halt = 1'b0;
      for (int i = 0; i < 4; i++) cycle("resume");

      // wrap of PC
      Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFC;
      cycle("wrap_redir");
      Redirect = 1'b0;
      cycle("wrap1");
      chk("wrap_pc_a", InstrPC, 32'hFFFF_FFFC);
      cycle("wrap2");
      chk("wrap_pc_b", InstrPC, 32'h0000_0000);
      for (int i = 0; i < 3; i++) cycle("wrap");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         InstrReady     = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) Halt = ~Halt;
         Redirect       = ($urandom_range(0, 15) == 0);
         RedirectTarget = $urandom;
         cycle("rand");
      end
      Redirect = 1'b0; Halt = 1'b0; InstrReady = 1'b1;
      for (int i = 0; i < 4; i++) cycle("settle");

      // asynchronous reset between edges
      @(negedge Clk); #2;
      Rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge Clk); #1;
      check_all("rst_held");
      Rst = 1'b1;
      cycle("rerel1");
      chk("restart_no_valid", 32'(InstrValid), 32'd0);
      cycle("rerel2");
      chk("restart_pc", InstrPC, 32'h0);
      for (int i = 0; i < 4; i++) cycle("restream");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, meaning the number of prefetch buffer entries; only 2 is supported.
REQ-003 The block SHALL have port Clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port Rst, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port ImemAddress, output, 32, the byte address driven to the combinational instruction memory.
REQ-006 The block SHALL have port ImemInstruction, input, 32, the word returned by that memory in the same cycle.
REQ-007 The block SHALL have port Redirect, input, 1, a branch/jump redirect strobe.
REQ-008 The block SHALL have port RedirectTarget, input, 32, the byte address of the new fetch stream.
REQ-009 The block SHALL have port Halt, input, 1, a level request to suspend fetching.
REQ-010 The block SHALL have port InstrValid, output, 1, which is high when the buffer head holds an instruction.
REQ-011 The block SHALL have port InstrReady, input, 1, the decode-stage accept signal.
REQ-012 The block SHALL have port InstrOut, output, 32, the instruction at the buffer head.
REQ-013 The block SHALL have port InstrPC, output, 32, the byte address of InstrOut.
REQ-014 The block SHALL have port FetchState, output, 2, the current FSM state encoding.

Function
REQ-015 The FSM SHALL have the states IDLE=0, FETCH=1 and HALTED=2; encoding 3 is unreachable and SHALL recover to IDLE.
REQ-016 The FSM SHALL transition from IDLE to FETCH unconditionally on the first rising edge after Rst deasserts.
REQ-017 The FSM SHALL transition from FETCH to HALTED on an edge where Halt=1, and from HALTED to FETCH on an edge where Halt=0.
REQ-018 ImemAddress SHALL equal the PC register combinationally.
REQ-019 A push SHALL occur in FETCH when Halt=0, Redirect=0 and (count<2 or a pop occurs this cycle); the push writes {PC, ImemInstruction} to the buffer tail and sets PC to PC+4.
REQ-020 A pop SHALL occur when InstrValid=1, InstrReady=1 and Redirect=0.
REQ-021 Simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-022 InstrValid, InstrOut and InstrPC SHALL be driven from registered buffer state with no combinational path from ImemInstruction.
REQ-023 The first InstrValid=1 SHALL appear on the 2nd rising edge after reset release, carrying InstrPC=RESET_PC.
REQ-024 In steady state with InstrReady held at 1, the block SHALL sustain one instruction per cycle.
REQ-025 Full condition: with count=2 and no pop, the block SHALL NOT push, PC SHALL hold, and buffer contents SHALL be unchanged.
REQ-026 Empty condition: with count=0, InstrValid SHALL be 0; InstrOut and InstrPC SHALL hold their last values.
REQ-027 On a Redirect edge, the block SHALL set PC to {RedirectTarget[31:2], 2'b00}, set count to 0 and InstrValid to 0, and SHALL neither push nor pop; Redirect SHALL take priority over Halt, push and pop.
REQ-028 A redirect in HALTED SHALL update PC and flush the buffer, and the state SHALL remain HALTED.
REQ-029 PC+4 SHALL wrap modulo 2^32; no range check is performed, since the memory indexes with ImemAddress[8:2].
REQ-030 In HALTED, the buffer SHALL continue to drain via pops.

Reset
REQ-031 Assertion of Rst=0 SHALL immediately set state=IDLE, PC=RESET_PC, count=0, InstrValid=0, InstrOut=0 and InstrPC=0, including mid-push or mid-redirect.
REQ-032 The block SHALL produce no push during IDLE.

Structure
REQ-033 The FSM state encodings, FIFO_DEPTH and the PC increment constant (4) SHALL reside in the shared package fetch_pkg.
REQ-034 The 2-entry {pc, instr} buffer SHALL be implemented as sub-module fetch_fifo, with push/pop/flush inputs and full/empty/count outputs.

Verification
REQ-035 Release reset with RESET_PC=0 and InstrReady=1 -> InstrValid rises at the 2nd edge; InstrPC sequence 0x0, 0x4, 0x8, ...; ImemAddress advances by 4 per cycle.
REQ-036 Hold InstrReady=0 for 5 cycles -> exactly 2 entries are buffered, PC stays at 0x8, and after InstrReady=1 the outputs are 0x0 then 0x4 in order.
REQ-037 Assert Redirect with RedirectTarget=0x43 while the buffer is full -> the next cycle has InstrValid=0 and ImemAddress=0x40, and the next delivered InstrPC is 0x40.
REQ-038 Assert Halt for 4 cycles with InstrReady=1 -> FetchState=2, the buffer drains to empty, and PC is frozen; on Halt=0, fetch resumes at the frozen PC.
REQ-039 Pulse Rst low mid-stream asynchronously between edges -> outputs immediately take their reset values, and the restart matches REQ-035.
REQ-040 Redirect to 0xFFFFFFFC -> delivered InstrPC values are 0xFFFFFFFC then 0x00000000.
